traffic_sensor_agent: RTL
=========================

// Module: traffic_sensor_agent
// PURPOSE
//  Vehicle-side driver for the 3-way traffic-light controller: turns per-lane car arrivals into
//  the N/S/E_SENSE request protocol and consumes N/S/E_GO grants. Queues arrivals per lane and
//  holds each car in the intersection for a programmable crossing time. Flags collisions and
//  starvation. Serves as the environment/stimulus partner when the controller is checked in
//  closed loop.
// PARAMETERS
//  QDEPTH_W   3    width of per-lane waiting-car counter (max 2**QDEPTH_W-1 queued cars)
//  CROSS_CYC  4    cycles a car stays in the intersection after GO is sampled high (>=1)
//  STARVE_CYC 64   cycles in WAIT without GO before starve_x asserts
//  CNT_W      16   width of served-car counters
// PORTS
//  clk          in   1      single clock; all state updates on posedge
//  reset_n      in   1      asynchronous active-low reset
//  arrive_n/s/e in   1 each pulse: one car arrives on that lane this cycle
//  n/s/e_go     in   1 each grant from controller
//  n/s/e_sense  out  1 each request/occupancy to controller
//  drop_x       out  3      {e,s,n} 1-cycle pulse: arrival lost, lane queue full
//  starve_x     out  3      {e,s,n} sticky: lane waited > STARVE_CYC cycles
//  collision    out  1      sticky: E car crossing concurrently with N or S car
//  served_n/s/e out  CNT_W  cars that completed crossing, wraps modulo 2**CNT_W
// BEHAVIOUR
//  Reset (async, reset_n=0): all FSMs IDLE, queues 0, all outputs 0 incl. sticky flags/counters.
//  Per-lane FSM (independent, identical):
//   IDLE : sense=0. If queue>0 (or arrival this cycle) -> WAIT next cycle; queue decrements by 1.
//   WAIT : sense=1, wait timer counts. go=1 sampled -> CROSS, cross timer loaded CROSS_CYC-1.
//          timer reaches STARVE_CYC -> starve_x set (stays until reset); FSM stays in WAIT.
//   CROSS: sense=1 (car in intersection). Timer decrements; at 0 -> EXIT, served_x += 1.
//          If go drops during CROSS: no error, car keeps crossing (controller only deasserts
//          go after sense=0).
//   EXIT : sense=0. Stay until go=0 sampled -> IDLE. Guarantees a new request never overlaps
//          the previous grant; minimum 1 cycle sense low between cars.
//  Latency: arrival at cycle t with IDLE lane and empty queue -> sense=1 at t+1.
//   go high at t -> sense falls at t+CROSS_CYC+1.
//  Queue: saturating counter. Arrival and dequeue in same cycle -> count unchanged.
//   Arrival while full and no dequeue -> count unchanged, drop_x pulse that cycle.
//  Collision: asserted (sticky) in any cycle where lane E is in CROSS and lane N or S is in
//   CROSS. N and S may cross together (legal).
//  served counters wrap 2**CNT_W-1 -> 0 without flag.
//  Reset mid-crossing: sense drops immediately (async); queued cars are discarded.
//  go asserted while lane IDLE/WAIT-less: ignored; no state change.
// STRUCTURE
//  Package traffic_pkg: lane_state_t enum {IDLE,WAIT,CROSS,EXIT}; LANE_N=0, LANE_S=1, LANE_E=2.
//  Sub-module traffic_lane_agent (queue, FSM, timers, served counter), instantiated 3x.
//  Top holds only collision and the output packing.
// TESTING
//  1 single arrive_n, go_n raised 2 cyc after n_sense, CROSS_CYC=4 -> n_sense high 7 cyc total,
//    falls 5 cyc after go_n, served_n=1.
//  2 8 arrive_s pulses back-to-back, no go, QDEPTH_W=3 -> 1 in WAIT + 7 queued, 8th... drop_x[1]
//    pulses on 9th arrival only; starve_x[1]=1 at 64 cycles in WAIT.
//  3 go_e held high permanently, 3 arrivals -> each car waits EXIT until go_e low; no second
//    sense before go_e drops.
//  4 n and e both in CROSS (go_n=go_e=1) -> collision=1 next cycle, stays after both leave;
//    n and s both crossing -> collision stays 0.
//  5 arrival and dequeue same cycle with queue=3 -> queue stays 3, no drop.
//  6 reset_n low mid-CROSS -> all sense=0 immediately, served/flags 0, queues empty after release.

Source files
------------

// File: rtl/traffic_sensor_agent_pkg.sv
// Shared types for the traffic sensor agent: lane FSM states and lane indices.
package traffic_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, CROSS, EXIT} lane_state_t;

    localparam int LANE_N    = 0;
    localparam int LANE_S    = 1;
    localparam int LANE_E    = 2;
    localparam int NUM_LANES = 3;
endpackage

// File: rtl/traffic_sensor_agent_if.sv
// Sensor/grant bundle between the vehicle-side agent (slave) and the environment (master).
interface traffic_sensor_agent_if #(
    parameter int CNT_W = 16
);
    logic             arrive_n, arrive_s, arrive_e;
    logic             n_go, s_go, e_go;
    logic             n_sense, s_sense, e_sense;
    logic [2:0]       drop_x;
    logic [2:0]       starve_x;
    logic             collision;
    logic [CNT_W-1:0] served_n, served_s, served_e;

    modport master (
        output arrive_n, arrive_s, arrive_e, n_go, s_go, e_go,
        input  n_sense, s_sense, e_sense, drop_x, starve_x, collision,
        input  served_n, served_s, served_e
    );

    modport slave (
        input  arrive_n, arrive_s, arrive_e, n_go, s_go, e_go,
        output n_sense, s_sense, e_sense, drop_x, starve_x, collision,
        output served_n, served_s, served_e
    );
endinterface

// File: rtl/traffic_sensor_agent_lane.sv
// One lane: saturating arrival queue, IDLE/WAIT/CROSS/EXIT FSM, wait/cross timers, served counter.
module traffic_lane_agent
    import traffic_pkg::*;
#(
    parameter int QDEPTH_W   = 3,
    parameter int CROSS_CYC  = 4,
    parameter int STARVE_CYC = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_arrive,
    input  logic             i_go,
    output logic             o_sense,
    output logic             o_drop,
    output logic             o_starve,
    output logic             o_cross,
    output logic [CNT_W-1:0] o_served
);
    localparam int WAIT_W  = (STARVE_CYC > 1) ? $clog2(STARVE_CYC) : 1;
    localparam int CROSS_W = (CROSS_CYC > 1) ? $clog2(CROSS_CYC) : 1;
    localparam logic [QDEPTH_W-1:0] QMAX       = '1;
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(STARVE_CYC - 1);
    localparam logic [CROSS_W-1:0]  CROSS_LOAD = CROSS_W'(CROSS_CYC - 1);

    lane_state_t         r_state;
    logic [QDEPTH_W-1:0] r_q;
    logic [WAIT_W-1:0]   r_wait;
    logic [CROSS_W-1:0]  r_cross;
    logic                r_starve;
    logic [CNT_W-1:0]    r_served;
    logic                w_deq;
    logic                w_full;

    // An idle lane takes the next car straight from the queue, or the arriving car if the queue is empty.
    assign w_deq  = (r_state == IDLE) && ((r_q != '0) || i_arrive);
    assign w_full = (r_q == QMAX);
    assign o_drop = i_arrive && !w_deq && w_full;

    assign o_sense  = (r_state == WAIT) || (r_state == CROSS);
    assign o_cross  = (r_state == CROSS);
    assign o_starve = r_starve;
    assign o_served = r_served;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_q      <= '0;
            r_wait   <= '0;
            r_cross  <= '0;
            r_starve <= 1'b0;
            r_served <= '0;
        end else begin
            if (i_arrive && !w_deq && !w_full)
                r_q <= r_q + 1'b1;
            else if (!i_arrive && w_deq)
                r_q <= r_q - 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_deq) begin
                        r_state <= WAIT;
                        r_wait  <= '0;
                    end
                end
                WAIT: begin
                    if (i_go) begin
                        r_state <= CROSS;
                        r_cross <= CROSS_LOAD;
                    end else if (r_wait == WAIT_LAST) begin
                        r_starve <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                CROSS: begin
                    // go may fall mid-crossing; the car finishes regardless.
                    if (r_cross == '0) begin
                        r_state  <= EXIT;
                        r_served <= r_served + 1'b1;
                    end else begin
                        r_cross <= r_cross - 1'b1;
                    end
                end
                EXIT: begin
                    if (!i_go) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/traffic_sensor_agent.sv
// Three independent lane agents plus the sticky E-vs-N/S collision detector.
module traffic_sensor_agent
    import traffic_pkg::*;
#(
    parameter int QDEPTH_W   = 3,
    parameter int CROSS_CYC  = 4,
    parameter int STARVE_CYC = 64,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    traffic_sensor_agent_if.slave  bus
);
    logic [NUM_LANES-1:0]            w_arrive;
    logic [NUM_LANES-1:0]            w_go;
    logic [NUM_LANES-1:0]            w_sense;
    logic [NUM_LANES-1:0]            w_drop;
    logic [NUM_LANES-1:0]            w_starve;
    logic [NUM_LANES-1:0]            w_cross;
    logic [NUM_LANES-1:0][CNT_W-1:0] w_served;
    logic                            r_collision;

    assign w_arrive = {bus.arrive_e, bus.arrive_s, bus.arrive_n};
    assign w_go     = {bus.e_go, bus.s_go, bus.n_go};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        traffic_lane_agent #(
            .QDEPTH_W  (QDEPTH_W),
            .CROSS_CYC (CROSS_CYC),
            .STARVE_CYC(STARVE_CYC),
            .CNT_W     (CNT_W)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_arrive (w_arrive[i]),
            .i_go     (w_go[i]),
            .o_sense  (w_sense[i]),
            .o_drop   (w_drop[i]),
            .o_starve (w_starve[i]),
            .o_cross  (w_cross[i]),
            .o_served (w_served[i])
        );
    end

    // N and S share a compatible path; only E against either of them is a conflict.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_collision <= 1'b0;
        else if (w_cross[LANE_E] && (w_cross[LANE_N] || w_cross[LANE_S]))
            r_collision <= 1'b1;
    end

    assign bus.n_sense   = w_sense[LANE_N];
    assign bus.s_sense   = w_sense[LANE_S];
    assign bus.e_sense   = w_sense[LANE_E];
    assign bus.drop_x    = w_drop;
    assign bus.starve_x  = w_starve;
    assign bus.collision = r_collision;
    assign bus.served_n  = w_served[LANE_N];
    assign bus.served_s  = w_served[LANE_S];
    assign bus.served_e  = w_served[LANE_E];
endmodule
